// File: rtl/mult_16.sv
// Sequential shift-add unsigned multiplier: WIDTH iterations per product,
// with the product and completion flag both registered.
module mult_16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_in,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Result,
    output logic                 done
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PW-1:0]      a_sh;
    logic [PW-1:0]      acc;
    logic [WIDTH-1:0]   b_sh;
    logic [CNT_W-1:0]   cnt;
    logic [PW-1:0]      sum_c;
    logic               last_c;

    // a_sh already carries the bit-position weight, so one full-width add per step
    assign sum_c  = b_sh[0] ? (acc + a_sh) : acc;
    assign last_c = (cnt == CNT_W'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (init_in)  state_nxt = ITER;
            ITER:    if (last_c)   state_nxt = DONE;
            DONE:    if (!init_in) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            cnt    <= '0;
            Result <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (init_in) begin
                        a_sh <= PW'(A);
                        b_sh <= B;
                        acc  <= '0;
                        cnt  <= CNT_W'(WIDTH);
                    end
                end
                ITER: begin
                    acc  <= sum_c;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt - CNT_W'(1);
                    if (last_c) Result <= sum_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_16.sv
// Self-checking bench for mult_16: directed vector table, reset abort
// sequence and randomized operations against a plain-arithmetic model.
module tb_mult_16;

    logic        clk;
    logic        rst;
    logic        init_in;
    logic [15:0] A;
    logic [15:0] B;
    logic [31:0] Result;
    logic        done;

    int          vectors;
    int          miscompares;
    logic [31:0] prev_res;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          hold;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[7];

    mult_16 #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .init_in (init_in),
        .A       (A),
        .B       (B),
        .Result  (Result),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start one operation from IDLE (called at a negedge); init_in is sampled
    // high at edges 0..hold-1. Operands are scrambled after edge 3.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input int hold, input logic [31:0] exp);
        int last;
        logic exp_done;
        last = (hold > 17) ? hold : 17;
        A = a;
        B = b;
        init_in = 1'b1;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 3) begin
                A = 16'hAAAA;
                B = 16'h5555;
            end
            init_in = (k + 1 < hold);
            exp_done = (k == 16) || (k > 16 && k < hold);
            check("done", 32'(done), 32'(exp_done));
            check("result", Result, (k >= 16) ? exp : prev_res);
        end
        prev_res = exp;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prev_res    = 32'h0;
        rst         = 1'b1;
        init_in     = 1'b0;
        A           = 16'h0;
        B           = 16'h0;

        tbl[0] = '{16'h0003, 16'h0005, 1,  32'h0000000F};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 1,  32'hFFFE0001};
        tbl[2] = '{16'h0000, 16'h1234, 1,  32'h00000000};
        tbl[3] = '{16'h1234, 16'h0100, 40, 32'h00123400};
        tbl[4] = '{16'h0007, 16'h0009, 1,  32'h0000003F};
        tbl[5] = '{16'h00FF, 16'h0101, 1,  32'h0000FFFF};
        tbl[6] = '{16'h8000, 16'h0002, 1,  32'h00010000};

        #12;
        check("reset_result", Result, 32'h0);
        check("reset_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_done", 32'(done), 32'h0);

        foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].exp);

        // Reset in the middle of an operation
        run_op(16'h0002, 16'h0002, 1, 32'h4);
        A = 16'h0010;
        B = 16'h0010;
        init_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init_in = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_result", Result, 32'h0);
        check("abort_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        prev_res = 32'h0;
        repeat (20) @(negedge clk);
        check("post_reset_idle_done", 32'(done), 32'h0);
        check("post_reset_idle_result", Result, 32'h0);
        run_op(16'h0006, 16'h0007, 1, 32'h0000002A);

        // Randomized operations against a plain product
        for (int n = 0; n < 20; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (n == 0) ra = 16'hFFFF;
            run_op(ra, rb, int'($urandom_range(1, 20)), 32'(ra) * 32'(rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_16.md
MULT_16 -- requirements
Module: mult_16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; product width is 2*WIDTH; all values below are for the default.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port init_in  input  1  start request, level-sampled in IDLE.
REQ-005 SHALL have port A  input  16  multiplicand, unsigned.
REQ-006 SHALL have port B  input  16  multiplier, unsigned.
REQ-007 SHALL have port Result  output  32  unsigned product A*B, registered.
REQ-008 SHALL have port done  output  1  completion flag, registered, high only in DONE.

Function
REQ-009 SHALL implement a shift-add sequential multiplier with a control FSM of states IDLE, ITER, DONE.
REQ-010 SHALL have an operand register for A, a shift register for B and a 32-bit accumulator, all internal.
REQ-011 SHALL use a bit counter loaded with 16 on start and decremented once per ITER cycle.
REQ-012 IDLE: on an edge with init_in=1, SHALL latch A and B, clear the accumulator, load the counter with 16 and go to ITER.
REQ-013 IDLE: while init_in=0, SHALL stay in IDLE with done=0.
REQ-014 ITER, each edge: if the B shift register LSB is 1, SHALL add the latched A, weighted by the current bit position, to the accumulator.
REQ-015 ITER, each edge: SHALL shift the B register right by 1 and decrement the counter.
REQ-016 SHALL perform the ITER add at full 32-bit width with no carry loss; 0xFFFF*0xFFFF SHALL give 0xFFFE0001.
REQ-017 SHALL run exactly 16 ITER edges, with no early exit for zero operands or zero remaining multiplier bits.
REQ-018 On the 16th ITER edge, SHALL copy the final sum into Result and go to DONE.
REQ-019 Latency: if init_in is sampled at edge 0, done and the valid Result SHALL be visible after edge 16.
REQ-020 DONE: SHALL drive done=1 and hold Result.
REQ-021 DONE: SHALL stay in DONE while init_in=1 and return to IDLE on the first edge with init_in=0.
REQ-022 A held-high init_in SHALL therefore start exactly one operation.
REQ-023 Result SHALL change only on the REQ-018 edge; it holds the previous product through IDLE and ITER of a new operation.
REQ-024 Changes on A and B after the start edge SHALL NOT affect the product in progress.
REQ-025 init_in SHALL be ignored during ITER.
REQ-026 done SHALL be deasserted on the same edge the FSM leaves DONE.

Reset
REQ-027 On rst=1, SHALL immediately force FSM=IDLE, counter=0, accumulator=0, operand registers=0, Result=0x00000000 and done=0, regardless of clk.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no partial Result update.
REQ-029 After rst deasserts, SHALL require a fresh init_in=1 sample in IDLE to start.

Verification
REQ-030 A=3, B=5, init_in pulsed 1 cycle -> Result=0x0000000F and done=1 exactly 16 edges after the start edge; done=0 one edge after DONE is entered with init_in=0.
REQ-031 A=0xFFFF, B=0xFFFF -> Result=0xFFFE0001, same latency; also A=0x0000, B=0x1234 -> Result=0, latency still 16.
REQ-032 A=0x1234, B=0x0100, init_in held high for 40 cycles -> one product 0x00123400; done held until init_in falls; no second start.
REQ-033 Start A=7, B=9, then change to A=0xAAAA, B=0x5555 at ITER cycle 3 -> Result=0x0000003F.
REQ-034 Complete 2*2=4, start 0x10*0x10, assert rst at ITER cycle 8 -> Result=0 and done=0 immediately; FSM in IDLE; a new start of 6*7 -> Result=0x2A after 16 edges.
REQ-035 Back-to-back: 0x00FF*0x0101, drop init_in one cycle in DONE, then start 0x8000*0x0002 -> Results 0x0000FFFF then 0x00010000; Result holds 0x0000FFFF during the second operation's ITER.
